inst_fetch_ctrl: RTL

//  Program-counter sequencer for the fetch stage: next-generation PC unit with parametrised

---
 rtl/inst_fetch_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch-stage program counter sequencer.
// Holds the PC at a selectable program base while Start is high, then steps
// through sequential, relative, absolute, call and return operations in RUN.
// Calls and returns use a small hardware return-address stack; overflow or
// underflow sets a sticky error flag that Start or Reset clears.
module inst_fetch_ctrl #(
    parameter int          PC_W       = 11,
    parameter int          OFF_W      = 8,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned PROG0_BASE = 0,
    parameter int unsigned PROG1_BASE = 0,
    parameter int unsigned PROG2_BASE = 0,
    parameter int unsigned PROG3_BASE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       ProgSel,
    input  logic             Stall,
    input  logic [2:0]       BrCtl,
    input  logic [OFF_W-1:0] Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic             RasFull,
    output logic             RasEmpty,
    output logic             RasErr
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_FWD  = 3'b001;
    localparam logic [2:0] OP_BACK = 3'b010;
    localparam logic [2:0] OP_ABS  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [1:0]       state_q, state_d;
    logic             armed_q, armed_d;   // Start was seen since entering IDLE
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic             push_s;
    logic [PC_W-1:0]  push_data_s;
    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [PC_W-1:0]  pc_inc_s;
    logic [PC_W-1:0]  tz_s;
    logic [PC_W-1:0]  base_s;
    logic             full_s;
    logic             empty_s;

    assign pc_inc_s   = pc_q + PC_W'(1);
    assign tz_s       = PC_W'(Target);
    assign full_s     = (cnt_q == CNT_MAX);
    assign empty_s    = (cnt_q == CNT_ZERO);
    assign push_idx_s = IDX_W'(cnt_q);
    assign top_idx_s  = IDX_W'(cnt_q - CNT_W'(1));

    // Select the start base for the requested program.
    always_comb begin
        base_s = PC_W'(PROG0_BASE);
        case (ProgSel)
            2'd0:    base_s = PC_W'(PROG0_BASE);
            2'd1:    base_s = PC_W'(PROG1_BASE);
            2'd2:    base_s = PC_W'(PROG2_BASE);
            2'd3:    base_s = PC_W'(PROG3_BASE);
            default: base_s = PC_W'(PROG0_BASE);
        endcase
    end

    // Next-state logic: Start beats Stall, Stall beats the branch op.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        push_s      = 1'b0;
        push_data_s = pc_inc_s;
        if (Start) begin
            pc_d    = base_s;
            state_d = ST_IDLE;
            armed_d = 1'b1;
            cnt_d   = CNT_ZERO;
            err_d   = 1'b0;
        end else if (Stall) begin
            pc_d = pc_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d = ST_RUN;
                        armed_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    case (BrCtl)
                        OP_SEQ:  pc_d = pc_inc_s;
                        OP_FWD:  pc_d = pc_q + tz_s;
                        OP_BACK: pc_d = pc_q - tz_s;
                        OP_ABS:  pc_d = tz_s;
                        OP_CALL: begin
                            if (!full_s) begin
                                push_s = 1'b1;
                                cnt_d  = cnt_q + CNT_W'(1);
                                pc_d   = tz_s;
                            end else begin
                                pc_d  = pc_inc_s;
                                err_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!empty_s) begin
                                pc_d  = ras_q[top_idx_s];
                                cnt_d = cnt_q - CNT_W'(1);
                            end else begin
                                pc_d  = pc_inc_s;
                                err_d = 1'b1;
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: pc_d = pc_inc_s;   // reserved op behaves as sequential
                    endcase
                end
                ST_HALT: pc_d = pc_q;
                default: state_d = ST_IDLE;          // recover from an illegal encoding
            endcase
        end
        done_d = (state_d == ST_HALT);
    end

    // Control and PC registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= {PC_W{1'b0}};
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Return-address storage; only the slot above the current top is written.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            ras_q[push_idx_s] <= push_data_s;
        end else begin
            ras_q <= ras_q;
        end
    end

    assign ProgCtr  = pc_q;
    assign Done     = done_q;
    assign RasErr   = err_q;
    assign RasFull  = full_s;
    assign RasEmpty = empty_s;

endmodule
